// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction fetch and the LSU.
// Define ARB_ROUND_ROBIN_EN for strict alternation instead of data-priority with a fetch bound.
module mem_arbiter #(
    parameter int unsigned MaxWait = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        if_req_i,
    input  logic [26:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        d_req_i,
    input  logic        d_wr_i,
    input  logic [7:0]  d_strb_i,
    input  logic [26:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [63:0] d_rdata_o,
    output logic        d_err_o,

    output logic        m_cen_o,
    output logic        m_wr_o,
    output logic [7:0]  m_strb_o,
    output logic [26:0] m_addr_o,
    output logic [63:0] m_wdata_o,
    input  logic [63:0] m_rdata_i,
    input  logic        m_error_i
);

    typedef enum logic {StIdle, StResp} state_e;
    typedef enum logic {OwnFetch = 1'b0, OwnData = 1'b1} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic        fetch_wins;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e      last_q, last_d;
`else
    localparam logic [3:0] MaxWaitC = 4'(MaxWait);
    logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;
        if_gnt_o   = 1'b0;
        d_gnt_o    = 1'b0;
        m_cen_o    = 1'b0;
        m_wr_o     = 1'b0;
        m_strb_o   = 8'h00;
        m_addr_o   = 27'h0;
        m_wdata_o  = 64'h0;
        fetch_wins = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`else
        wait_cnt_d = wait_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (if_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    fetch_wins = (last_q == OwnData);
`else
                    fetch_wins = (wait_cnt_q == MaxWaitC);
`endif
                end else begin
                    fetch_wins = if_req_i;
                end

                if (if_req_i || d_req_i) begin
                    state_d = StResp;
                    if (fetch_wins) begin
                        if_gnt_o   = 1'b1;
                        m_cen_o    = 1'b1;
                        m_strb_o   = 8'h0F;
                        m_addr_o   = if_addr_i;
                        owner_d    = OwnFetch;
                        if_rdata_d = m_rdata_i[31:0];
                        // Fetch never reports errors.
                        d_err_d    = 1'b0;
                    end else begin
                        d_gnt_o   = 1'b1;
                        m_cen_o   = 1'b1;
                        m_wr_o    = d_wr_i;
                        m_strb_o  = d_strb_i;
                        m_addr_o  = d_addr_i;
                        m_wdata_o = d_wdata_i;
                        owner_d   = OwnData;
                        d_rdata_d = d_wr_i ? 64'h0 : m_rdata_i;
                        d_err_d   = m_error_i;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d = owner_d;
`endif
                end

`ifndef ARB_ROUND_ROBIN_EN
                if (!if_req_i || fetch_wins) begin
                    wait_cnt_d = 4'h0;
                end else if (d_req_i && (wait_cnt_q < MaxWaitC)) begin
                    wait_cnt_d = wait_cnt_q + 4'h1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            owner_q    <= OwnFetch;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 64'h0;
            d_err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            // Reset to fetch so data wins the first tie.
            last_q     <= OwnFetch;
`else
            wait_cnt_q <= 4'h0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign if_rvalid_o = (state_q == StResp) && (owner_q == OwnFetch);
    assign d_rvalid_o  = (state_q == StResp) && (owner_q == OwnData);
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-masked memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [26:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_wr, d_gnt, d_rvalid, d_err;
    logic [7:0]  d_strb;
    logic [26:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic        m_cen, m_wr, m_error;
    logic [7:0]  m_strb;
    logic [26:0] m_addr;
    logic [63:0] m_wdata, m_rdata;

    logic [63:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .d_req_i     (d_req),
        .d_wr_i      (d_wr),
        .d_strb_i    (d_strb),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .m_cen_o     (m_cen),
        .m_wr_o      (m_wr),
        .m_strb_o    (m_strb),
        .m_addr_o    (m_addr),
        .m_wdata_o   (m_wdata),
        .m_rdata_i   (m_rdata),
        .m_error_i   (m_error)
    );

    function automatic logic [63:0] mask_bytes(input logic [63:0] w, input logic [7:0] s);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = s[i] ? w[i*8 +: 8] : 8'h00;
        return r;
    endfunction

    assign m_rdata = (m_cen && !m_wr) ? mask_bytes(mem[m_addr[10:3]], m_strb) : 64'h0;

    always @(posedge clk) begin
        if (m_cen && m_wr) begin
            for (int i = 0; i < 8; i++)
                if (m_strb[i]) mem[m_addr[10:3]][i*8 +: 8] <= m_wdata[i*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Grant pattern {if_gnt, d_gnt} for each grant slot with both requesters held.
    localparam logic [1:0] GD = 2'b01;
    localparam logic [1:0] GI = 2'b10;
    logic [1:0] exp_seq [10];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{GD, GI, GD, GI, GD, GI, GD, GI, GD, GI};
`else
        exp_seq = '{GD, GD, GD, GD, GI, GD, GD, GD, GD, GI};
`endif
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'h20] = 64'h0000_0000_0000_0013;  // byte address 0x100
        rst_n = 1'b0; if_req = 1'b0; if_addr = 27'h0; d_req = 1'b0; d_wr = 1'b0;
        d_strb = 8'h00; d_addr = 27'h0; d_wdata = 64'h0; m_error = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_if_gnt",    64'(if_gnt),    64'h0);
        check("rst_d_gnt",     64'(d_gnt),     64'h0);
        check("rst_if_rvalid", 64'(if_rvalid), 64'h0);
        check("rst_d_rvalid",  64'(d_rvalid),  64'h0);
        check("rst_if_rdata",  64'(if_rdata),  64'h0);
        check("rst_d_rdata",   d_rdata,        64'h0);
        check("rst_d_err",     64'(d_err),     64'h0);
        check("rst_m_cen",     64'(m_cen),     64'h0);
        check("rst_m_addr",    64'(m_addr),    64'h0);

        // Both requesters held: grant every other cycle in the expected owner order.
        next_cycle();
        if_req = 1'b1; if_addr = 27'h100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 27'h200; d_strb = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("seq_gnt%0d", k), 64'({if_gnt, d_gnt}),
                  (k % 2 == 1) ? 64'h0 : 64'(exp_seq[k/2]));
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Single fetch.
        if_req = 1'b1; if_addr = 27'h100;
        @(negedge clk);
        check("f_if_gnt", 64'(if_gnt), 64'h1);
        check("f_d_gnt",  64'(d_gnt),  64'h0);
        check("f_m_cen",  64'(m_cen),  64'h1);
        check("f_m_wr",   64'(m_wr),   64'h0);
        check("f_m_strb", 64'(m_strb), 64'h0F);
        check("f_m_addr", 64'(m_addr), 64'h100);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        check("f_if_rvalid", 64'(if_rvalid), 64'h1);
        check("f_if_rdata",  64'(if_rdata),  64'h13);
        check("f_resp_gnt",  64'(if_gnt),    64'h0);
        check("f_resp_mcen", 64'(m_cen),     64'h0);
        next_cycle();

        // Store then load at 0x200.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 27'h200; d_strb = 8'hFF;
        d_wdata = 64'h1122334455667788;
        @(negedge clk);
        check("st_d_gnt",   64'(d_gnt), 64'h1);
        check("st_m_wr",    64'(m_wr),  64'h1);
        check("st_m_wdata", m_wdata,    64'h1122334455667788);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("st_d_rvalid", 64'(d_rvalid), 64'h1);
        check("st_d_rdata",  d_rdata,       64'h0);
        next_cycle();
        d_req = 1'b1; d_wr = 1'b0; d_wdata = 64'h0;
        @(negedge clk);
        check("ld_d_gnt", 64'(d_gnt), 64'h1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("ld_d_rvalid", 64'(d_rvalid), 64'h1);
        check("ld_d_rdata",  d_rdata,       64'h1122334455667788);
        next_cycle();
        @(negedge clk);
        check("hold_d_rdata", d_rdata, 64'h1122334455667788);

        // Error on data access is reported; on fetch it is suppressed.
        next_cycle();
        d_req = 1'b1; m_error = 1'b1;
        @(negedge clk);
        check("de_d_gnt", 64'(d_gnt), 64'h1);
        next_cycle();
        d_req = 1'b0; m_error = 1'b0;
        @(negedge clk);
        check("de_d_rvalid", 64'(d_rvalid), 64'h1);
        check("de_d_err",    64'(d_err),    64'h1);
        next_cycle();
        if_req = 1'b1; m_error = 1'b1;
        @(negedge clk);
        check("fe_if_gnt", 64'(if_gnt), 64'h1);
        next_cycle();
        if_req = 1'b0; m_error = 1'b0;
        @(negedge clk);
        check("fe_if_rvalid", 64'(if_rvalid), 64'h1);
        check("fe_d_rvalid",  64'(d_rvalid),  64'h0);
        check("fe_d_err",     64'(d_err),     64'h0);
        next_cycle();

        // Reset asserted in the response cycle kills the response.
        d_req = 1'b1; d_wr = 1'b0;
        @(negedge clk);
        check("rr_d_gnt", 64'(d_gnt), 64'h1);
        next_cycle();
        d_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rr_d_rvalid",  64'(d_rvalid),  64'h0);
        check("rr_if_rvalid", 64'(if_rvalid), 64'h0);
        check("rr_d_rdata",   d_rdata,        64'h0);
        check("rr_if_rdata",  64'(if_rdata),  64'h0);
        check("rr_d_err",     64'(d_err),     64'h0);
        check("rr_m_cen",     64'(m_cen),     64'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_post_d_rvalid", 64'(d_rvalid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported 128 MB byte-addressed memory between the instruction-fetch unit and the load/store unit of the multi-cycle core. Sits between the core front-end/LSU and the memory model. Grants one access per transaction, drives the memory port combinationally during the grant cycle, registers the read data, and returns it one cycle later with a valid pulse. Default policy is data-priority with a bounded-starvation counter for fetch.

## Interface
- MAX_WAIT, 4: consecutive fetch losses tolerated before fetch is forced to win; legal range 1–15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  27  fetch byte address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held with d_wr/d_strb/d_addr/d_wdata stable until d_gnt.
- d_wr  in  1  1 = store, 0 = load.
- d_strb  in  8  byte enables.
- d_addr  in  27  data byte address.
- d_wdata  in  64  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data response, one-cycle pulse (loads and stores).
- d_rdata  out  64  load data; 0 for stores.
- d_err  out  1  registered copy of m_error, valid with d_rvalid.
- m_cen  out  1  memory data-port enable.
- m_wr  out  1  memory write.
- m_strb  out  8  memory byte enables.
- m_addr  out  27  memory address.
- m_wdata  out  64  memory write data.
- m_rdata  in  64  memory read data (combinational, masked by strobe).
- m_error  in  1  memory error flag.

## Operation
- States: IDLE, RESP. Reset → IDLE.
- IDLE, no request: all m_* = 0, no grant.
- IDLE, request(s): exactly one of if_gnt/d_gnt = 1. Winner's signals on memory port; next state RESP.
  - Fetch access: m_wr = 0, m_strb = 8'h0F, m_addr = if_addr, m_wdata = 0.
  - Data access: m_wr/m_strb/m_addr/m_wdata = d_wr/d_strb/d_addr/d_wdata.
- Clock edge leaving IDLE with grant: capture m_rdata[63:0] (fetch keeps [31:0]), m_error, and owner (fetch/data) into registers.
- RESP: pulse owner's rvalid with registered data; no grants; memory port idle; return to IDLE.
- Selection (default): d_req wins unless wait_cnt == MAX_WAIT and if_req = 1, then fetch wins.
- wait_cnt (4-bit): +1 when both request and data wins; cleared when fetch granted or if_req = 0 in IDLE; saturates at MAX_WAIT.
- Fetch responses always have error ignored; d_err = 0 on fetch responses.

## Timing
- Reset values: if_gnt = d_gnt = 0, if_rvalid = d_rvalid = 0, if_rdata = 0, d_rdata = 0, d_err = 0, all m_* = 0, wait_cnt = 0, state IDLE.
- Grant in cycle N, rvalid in cycle N+1; peak throughput one access per 2 cycles.
- Requests arriving during RESP wait; earliest grant is cycle N+2.
- rdata/d_err registers hold last captured value between pulses.
- rst_n asserted in RESP: rvalid dropped, no response delivered; requester must re-request after reset.
- Request deasserted before grant: legal, no access performed.

## Configuration
- ARB_ROUND_ROBIN_EN defined: strict alternation replaces data-priority; a last-owner bit (reset = fetch, so data wins first tie) gives the tie to the other requester; wait_cnt and MAX_WAIT unused.
- Undefined: data-priority with MAX_WAIT starvation bound as above.

## Test plan
- Reset, then if_req = 1, if_addr = 27'h100, memory word 0x00000013 → if_gnt cycle 0, m_strb = 8'h0F, if_rvalid cycle 1 with if_rdata = 32'h00000013.
- d_req store d_addr = 27'h200, d_strb = 8'hFF, d_wdata = 64'h1122334455667788, then load same address → store d_rvalid with d_rdata = 0; load d_rdata = 64'h1122334455667788.
- if_req and d_req held continuously, MAX_WAIT = 4 → grant sequence D,D,D,D,I,D,D,D,D,I; grants every second cycle.
- ARB_ROUND_ROBIN_EN defined, both requesting continuously → grants D,I,D,I; never two consecutive same owner.
- Grant data load at cycle N, assert rst_n = 0 in cycle N+1 → d_rvalid stays 0; all outputs 0; wait_cnt = 0.
- m_error = 1 during data grant → d_err = 1 with d_rvalid; m_error = 1 during fetch grant → d_err = 0.
